// File: rtl/button_conditioner.sv
// Conditions the five raw board push-buttons: 2-FF synchronizer, counter debounce,
// debounced level, one-cycle press strobe and optional auto-repeat per button.
module button_conditioner #(
    parameter int          DEBOUNCE_CYCLES = 4,
    parameter int          REPEAT_DELAY    = 8,
    parameter int          REPEAT_PERIOD   = 4,
    parameter logic [4:0]  REPEAT_MASK     = 5'b01010
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       CENTER,
    input  logic       UP,
    input  logic       LEFT,
    input  logic       DOWN,
    input  logic       RIGHT,
    output logic [4:0] btn_level,
    output logic [4:0] btn_press,
    output logic       any_press
);

    localparam int DCW     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RCW     = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;

    localparam logic [DCW-1:0] DB_LAST     = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RCW-1:0] DELAY_LAST  = RCW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [RCW-1:0] PERIOD_LAST = RCW'((REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0);
    localparam logic [4:0]     REPEAT_EN   = (REPEAT_DELAY > 0) ? REPEAT_MASK : 5'b00000;

    logic [4:0]     w_raw;
    logic [4:0]     r_sync1;
    logic [4:0]     r_sync2;
    logic [DCW-1:0] r_dbCnt    [5];
    logic [RCW-1:0] r_repCnt   [5];
    logic [4:0]     r_repPhase;

    logic [4:0]     w_dbDone;
    logic [4:0]     w_rise;
    logic [4:0]     w_fall;
    logic [4:0]     w_repHit;
    logic [4:0]     w_pressNext;
    logic [RCW-1:0] w_repLimit [5];

    assign w_raw = {RIGHT, DOWN, LEFT, UP, CENTER};

    // A level change is accepted on the edge where the counter has seen the
    // new value for DEBOUNCE_CYCLES edges; repeat strobes are suppressed on that
    // same edge when the level is falling.
    always_comb begin
        w_dbDone    = '0;
        w_rise      = '0;
        w_fall      = '0;
        w_repHit    = '0;
        w_pressNext = '0;
        for (int i = 0; i < 5; i++) begin
            w_repLimit[i]  = r_repPhase[i] ? PERIOD_LAST : DELAY_LAST;
            w_dbDone[i]    = (r_sync2[i] != btn_level[i]) && (r_dbCnt[i] == DB_LAST);
            w_rise[i]      = w_dbDone[i] && r_sync2[i];
            w_fall[i]      = w_dbDone[i] && !r_sync2[i];
            w_repHit[i]    = REPEAT_EN[i] && btn_level[i] && !w_fall[i]
                             && (r_repCnt[i] == w_repLimit[i]);
            w_pressNext[i] = w_rise[i] || w_repHit[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_repPhase <= '0;
            btn_level  <= '0;
            btn_press  <= '0;
            any_press  <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                r_dbCnt[i]  <= '0;
                r_repCnt[i] <= '0;
            end
        end else begin
            r_sync1   <= w_raw;
            r_sync2   <= r_sync1;
            btn_press <= w_pressNext;
            any_press <= |w_pressNext;
            for (int i = 0; i < 5; i++) begin
                if (r_sync2[i] == btn_level[i]) begin
                    r_dbCnt[i] <= '0;
                end else if (r_dbCnt[i] == DB_LAST) begin
                    btn_level[i] <= r_sync2[i];
                    r_dbCnt[i]   <= '0;
                end else begin
                    r_dbCnt[i] <= r_dbCnt[i] + 1'b1;
                end

                // Repeat counter reloads on every strobe, so it can never wrap.
                if (!btn_level[i] || w_fall[i] || !REPEAT_EN[i]) begin
                    r_repCnt[i]   <= '0;
                    r_repPhase[i] <= 1'b0;
                end else if (r_repCnt[i] == w_repLimit[i]) begin
                    r_repCnt[i]   <= '0;
                    r_repPhase[i] <= 1'b1;
                end else begin
                    r_repCnt[i] <= r_repCnt[i] + 1'b1;
                end
            end
        end
    end

endmodule
